// File: rtl/strm_func_engine.sv
// Streaming function engine: command-selected per-beat transform (bypass / moving average / scale).
// Define STRM_FUNC_MA_EN to build the moving-average history; otherwise op 4'b0001 is unsupported.
module strm_func_engine #(
  parameter int DW       = 16,
  parameter int ODW      = 32,
  parameter int MA_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [31:0]    cmd_word,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [DW-1:0]  s_data,
  input  logic           s_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [ODW-1:0] m_data,
  output logic           m_last,
  output logic           busy,
  output logic [3:0]     op_code,
  output logic           err_unsup,
  output logic [15:0]    beat_cnt
);
  localparam int MA_LOG2 = $clog2(MA_DEPTH);
  localparam int SH_MAX  = ODW - DW;

  typedef enum logic {ST_COMMAND_DECODE, ST_ACTIVE} state_t;

  state_t           r_state, w_state_next;
  logic [3:0]       r_op_code;
  logic [4:0]       r_shamt;
  logic [15:0]      r_beat_cnt;
  logic             r_err_unsup;
  logic             r_m_valid, r_m_last;
  logic [ODW-1:0]   r_m_data;
  logic             w_cmd_acc, w_s_acc, w_sup;
  logic [4:0]       w_shamt_eff;
  logic [ODW-1:0]   w_s_ext, w_scaled, w_ma_data, w_result;
  logic             w_unused_params;

  function automatic logic f_supported(input logic [3:0] op);
`ifdef STRM_FUNC_MA_EN
    return (op == 4'h0) || (op == 4'h1) || (op == 4'h8);
`else
    return (op == 4'h0) || (op == 4'h8);
`endif
  endfunction

  assign w_unused_params = ^cmd_word[27:5];
  assign w_sup     = f_supported(r_op_code);
  assign w_cmd_acc = cmd_valid && cmd_ready;
  assign w_s_acc   = s_valid && s_ready;

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    s_ready      = 1'b0;
    case (r_state)
      ST_COMMAND_DECODE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Unsupported ops drain the packet at full rate without producing output.
        s_ready = !w_sup || !r_m_valid || m_ready;
        if (s_valid && s_ready && s_last) w_state_next = ST_COMMAND_DECODE;
      end
      default: w_state_next = ST_COMMAND_DECODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_COMMAND_DECODE;
      r_op_code   <= 4'h0;
      r_shamt     <= 5'd0;
      r_beat_cnt  <= 16'd0;
      r_err_unsup <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_err_unsup <= w_cmd_acc && !f_supported(cmd_word[31:28]);
      if (w_cmd_acc) begin
        r_op_code  <= cmd_word[31:28];
        r_shamt    <= cmd_word[4:0];
        r_beat_cnt <= 16'd0;
      end else if (w_s_acc) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

  assign w_s_ext     = {{(ODW-DW){1'b0}}, s_data};
  assign w_shamt_eff = ({27'd0, r_shamt} > 32'(SH_MAX)) ? 5'(SH_MAX) : r_shamt;
  assign w_scaled    = w_s_ext << w_shamt_eff;

`ifdef STRM_FUNC_MA_EN
  logic [DW-1:0]      r_hist [MA_DEPTH];
  logic [DW-1:0]      r_ma_oldest_rd;
  logic [MA_LOG2-1:0] r_ma_ptr, w_ma_ptr_next;
  logic [MA_LOG2:0]   r_ma_fill;
  logic [ODW-1:0]     r_ma_sum, w_ma_sum_new, w_oldest_ext;
  logic               w_ma_acc;

  assign w_ma_acc      = w_s_acc && (r_op_code == 4'h1);
  assign w_ma_ptr_next = w_cmd_acc ? '0 : (w_ma_acc ? r_ma_ptr + 1'b1 : r_ma_ptr);
  // Until the window has filled, the slot being replaced counts as zero; this
  // avoids having to clear the history RAM at command start.
  assign w_oldest_ext  = r_ma_fill[MA_LOG2] ? {{(ODW-DW){1'b0}}, r_ma_oldest_rd} : '0;
  assign w_ma_sum_new  = r_ma_sum + w_s_ext - w_oldest_ext;
  assign w_ma_data     = w_ma_sum_new >> MA_LOG2;

  // Registered read prefetches the slot the next accepted beat will overwrite.
  always_ff @(posedge clk) begin
    if (w_ma_acc) r_hist[r_ma_ptr] <= s_data;
    r_ma_oldest_rd <= r_hist[w_ma_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (rst || w_cmd_acc) begin
      r_ma_ptr  <= '0;
      r_ma_fill <= '0;
      r_ma_sum  <= '0;
    end else if (w_ma_acc) begin
      r_ma_ptr <= w_ma_ptr_next;
      r_ma_sum <= w_ma_sum_new;
      if (!r_ma_fill[MA_LOG2]) r_ma_fill <= r_ma_fill + 1'b1;
    end
  end
`else
  assign w_ma_data = '0;
`endif

  always_comb begin
    case (r_op_code)
      4'h1:    w_result = w_ma_data;
      4'h8:    w_result = w_scaled;
      default: w_result = w_s_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_s_acc && w_sup) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_result;
      r_m_last  <= s_last;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;
  assign busy      = (r_state == ST_ACTIVE);
  assign op_code   = r_op_code;
  assign err_unsup = r_err_unsup;
  assign beat_cnt  = r_beat_cnt;
endmodule

// File: tb/tb_strm_func_engine.sv
// Self-checking bench for strm_func_engine: directed cases plus randomized packets
// against a queue-based reference model; output stream checked by a monitor.
module tb_strm_func_engine;
  localparam int DW = 16, ODW = 32, MA_DEPTH = 8;
`ifdef STRM_FUNC_MA_EN
  localparam bit MA_ON = 1'b1;
`else
  localparam bit MA_ON = 1'b0;
`endif

  typedef struct {logic [31:0] d; logic l;} out_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_ready;
  logic [31:0]    cmd_word;
  logic           s_valid, s_ready, s_last;
  logic [DW-1:0]  s_data;
  logic           m_valid, m_ready, m_last;
  logic [ODW-1:0] m_data;
  logic           busy, err_unsup;
  logic [3:0]     op_code;
  logic [15:0]    beat_cnt;

  int   vectors = 0, miscompares = 0;
  out_t exp_q[$];
  int   hist_q[$];
  logic [3:0] cur_op;
  int   cur_sh, exp_beats;
  bit   bp_en = 1'b0;
  logic m_ready_force = 1'b1;

  strm_func_engine #(.DW(DW), .ODW(ODW), .MA_DEPTH(MA_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .op_code(op_code), .err_unsup(err_unsup), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_sup(input logic [3:0] op);
    return (op == 4'h0) || (op == 4'h8) || (MA_ON && op == 4'h1);
  endfunction

  // Reference: average of the last MA_DEPTH samples (missing ones are zero).
  function automatic logic [31:0] model_out(input logic [15:0] d);
    int sum, sh;
    sum = 0;
    case (cur_op)
      4'h1: begin
        hist_q.push_back(int'(d));
        if (hist_q.size() > MA_DEPTH) void'(hist_q.pop_front());
        foreach (hist_q[i]) sum += hist_q[i];
        return 32'(sum / MA_DEPTH);
      end
      4'h8: begin
        sh = (cur_sh > ODW - DW) ? ODW - DW : cur_sh;
        return 32'(d) << sh;
      end
      default: return 32'(d);
    endcase
  endfunction

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = bp_en ? 1'($urandom_range(0, 1)) : m_ready_force;
    end
  end

  // Output monitor: ordering/content against the model queue, and hold-while-stalled.
  initial begin
    bit prev_stall;
    logic [31:0] prev_d;
    logic prev_l;
    out_t e;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", m_data, prev_d);
          check("hold_last", 32'(m_last), 32'(prev_l));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 32'(m_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", m_data, e.d);
            check("out_last", 32'(m_last), 32'(e.l));
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_d = m_data;
        prev_l = m_last;
      end
    end
  end

  task automatic set_ready(input logic v);
    m_ready_force = v;
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_err", 32'(err_unsup), 32'd0);
    check("rst_op_code", 32'(op_code), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_s_ready", 32'(s_ready), 32'd0);
  endtask

  task automatic command(input logic [31:0] w);
    int n;
    bit sup;
    n = 0;
    cmd_valid = 1'b1;
    cmd_word = w;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    check("cmd_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cur_op = w[31:28];
    cur_sh = int'(w[4:0]);
    hist_q.delete();
    exp_beats = 0;
    sup = is_sup(cur_op);
    check("cmd_busy", 32'(busy), 32'd1);
    check("cmd_op_code", 32'(op_code), 32'(cur_op));
    check("cmd_beat_cnt", 32'(beat_cnt), 32'd0);
    check("err_unsup_pulse", 32'(err_unsup), 32'(!sup));
    @(posedge clk); #1;
    check("err_unsup_width", 32'(err_unsup), 32'd0);
  endtask

  task automatic beat(input logic [15:0] d, input logic l);
    int n;
    bit sup;
    logic rdy_at;
    logic [31:0] ev;
    n = 0;
    ev = '0;
    sup = is_sup(cur_op);
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("beat_accept", 32'(s_ready), 32'd1);
    if (!sup) check("drop_no_wait", 32'(n), 32'd0);
    rdy_at = m_ready;
    if (sup) begin
      ev = model_out(d);
      exp_q.push_back('{ev, l});
    end
    exp_beats++;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    check("beat_cnt", 32'(beat_cnt), 32'(exp_beats & 16'hFFFF));
    if (sup && rdy_at) begin
      check("lat1_valid", 32'(m_valid), 32'd1);
      check("lat1_data", m_data, ev);
    end
    if (l) check("busy_after_last", 32'(busy), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    if (!bp_en && m_ready_force) check("idle_m_valid", 32'(m_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] ops [6];
    logic [31:0] w;
    int len;
    ops = '{4'h0, 4'h1, 4'h8, 4'h2, 4'h4, 4'hF};
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_word = '0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    command(32'h0000_0000);
    beat(16'h1234, 1'b0);
    beat(16'hFFFF, 1'b1);
    drain();

    command(32'h1000_0000);
    for (int i = 0; i < 9; i++) beat(16'd16, i == 8);
    drain();

    command(32'h8000_0004);
    beat(16'h1234, 1'b1);
    command(32'h8000_0014);
    beat(16'h1234, 1'b1);
    drain();

    command(32'h2000_0000);
    for (int i = 0; i < 3; i++) beat(16'(i + 7), i == 2);
    command(32'h4000_0000);
    beat(16'hABCD, 1'b1);
    drain();

    // Downstream stall: one beat held, second beat blocked for five cycles.
    command(32'h0000_0000);
    set_ready(1'b0);
    beat(16'h1111, 1'b0);
    s_valid = 1'b1;
    s_data = 16'h2222;
    s_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_s_ready", 32'(s_ready), 32'd0);
      check("stall_m_data", m_data, 32'h0000_1111);
    end
    m_ready_force = 1'b1;
    @(posedge clk); #1;
    beat(16'h2222, 1'b1);
    drain();

    // Reset in the middle of a packet with an output pending.
    command(32'h0000_0000);
    set_ready(1'b0);
    beat(16'h5555, 1'b0);
    do_reset();
    set_ready(1'b1);

    bp_en = 1'b1;
    for (int p = 0; p < 25; p++) begin
      w = {ops[$urandom_range(0, 5)], 23'($urandom), 5'($urandom)};
      command(w);
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) beat(16'($urandom), i == len - 1);
    end
    bp_en = 1'b0;
    m_ready_force = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
